// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - result handshake interface for the PWM capture block
interface pwm_capture_if #(
    parameter int CNT_WIDTH = 32
) ();
    logic                 valid;
    logic                 ready;
    logic [CNT_WIDTH-1:0] high;
    logic [CNT_WIDTH-1:0] period;

    modport master (output valid, output high, output period, input ready);
    modport slave  (input valid, input high, input period, output ready);
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures active time and period of an external PWM on prescaled ticks
module pwm_capture #(
    parameter int CNT_WIDTH   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 pol,
    input  logic [CNT_WIDTH-1:0] pscr,
    input  logic [CNT_WIDTH-1:0] timeout,
    input  logic                 clr,
    input  logic                 pwm,
    pwm_capture_if.master        res,
    output logic                 busy,
    output logic                 ovr,
    output logic                 tmo
);
    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                 lvl, lvl_d, rise, fall;
    logic [CNT_WIDTH-1:0] pre, div, ph, per, high_tmp, ph_cap, per_cap;
    logic                 tick, tmo_hit;
    logic                 clr_cnt, clr_ph, ld_high, new_res, tmo_set, drop;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a, input logic b);
        return (a == '1) ? a : a + {{(CNT_WIDTH-1){1'b0}}, b};
    endfunction

    // Polarity is folded in before the delay flop so both edges see the same latency
    assign lvl  = sync[SYNC_STAGES-1] ^ pol;
    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            lvl_d <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], pwm};
            lvl_d <= lvl;
        end
    end

    assign div  = (pscr == '0) ? ONE : pscr;
    assign tick = en && (pre == div - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              pre <= '0;
        else if (!en || tick)    pre <= '0;
        else                     pre <= pre + ONE;
    end

    assign ph_cap  = sat_add(ph, tick);
    assign per_cap = sat_add(per, tick);
    assign tmo_hit = (timeout != '0) && tick &&
                     (({1'b0, per} + {{CNT_WIDTH{1'b0}}, 1'b1}) >= {1'b0, timeout});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
        clr_ph    = 1'b0;
        ld_high   = 1'b0;
        new_res   = 1'b0;
        tmo_set   = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            clr_cnt   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARM;
                    clr_cnt   = 1'b1;
                end
                ARM: begin
                    clr_cnt = 1'b1;
                    if (rise) state_nxt = HIGH;
                end
                HIGH: begin
                    if (tmo_hit) begin
                        tmo_set   = 1'b1;
                        clr_cnt   = 1'b1;
                        state_nxt = ARM;
                    end else if (fall) begin
                        ld_high   = 1'b1;
                        clr_ph    = 1'b1;
                        state_nxt = LOW;
                    end
                end
                LOW: begin
                    if (tmo_hit) begin
                        tmo_set   = 1'b1;
                        clr_cnt   = 1'b1;
                        state_nxt = ARM;
                    end else if (rise) begin
                        new_res   = 1'b1;
                        clr_cnt   = 1'b1;
                        state_nxt = HIGH;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= '0;
            per      <= '0;
            high_tmp <= '0;
        end else begin
            if (clr_cnt) begin
                ph  <= '0;
                per <= '0;
            end else begin
                ph  <= clr_ph ? '0 : ph_cap;
                per <= per_cap;
            end
            if (ld_high) high_tmp <= ph_cap;
        end
    end

    // A held, unaccepted result is never overwritten; the newcomer is dropped instead
    assign drop = new_res && res.valid && !res.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res.valid  <= 1'b0;
            res.high   <= '0;
            res.period <= '0;
        end else if (!en) begin
            res.valid <= 1'b0;
        end else if (new_res && !drop) begin
            res.valid  <= 1'b1;
            res.high   <= high_tmp;
            res.period <= per_cap;
        end else if (res.valid && res.ready) begin
            res.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr <= 1'b0;
            tmo <= 1'b0;
        end else begin
            if (drop)         ovr <= 1'b1;
            else if (clr)     ovr <= 1'b0;
            if (tmo_set)      tmo <= 1'b1;
            else if (clr)     tmo <= 1'b0;
        end
    end

    assign busy = (state == HIGH) || (state == LOW);
endmodule
